// File: rtl/ps2_packet_receiver_pkg.sv
// Shared definitions for the PS/2 packet receiver.
//   frame_state_t : per-byte frame FSM states
//   byte_idx_t    : position of the next byte within the 3-byte packet
//   *_LSB / *_BIT : field offsets inside the 32-bit packet record
//   odd_parity    : true when data plus parity bit carry an odd number of ones
package ps2_packet_receiver_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYC = 20000;

  localparam int unsigned STATUS_LSB = 16;
  localparam int unsigned X_LSB      = 8;
  localparam int unsigned Y_LSB      = 0;
  localparam int unsigned LEFT_BIT   = 16;
  localparam int unsigned RIGHT_BIT  = 17;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    BYTE0,
    BYTE1,
    BYTE2
  } byte_idx_t;

  function automatic logic odd_parity(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_packet_receiver_if.sv
// Bus bundle between the PS/2 packet receiver and its environment.
//   ps2_clk, ps2_data : PS/2 lines (input-only to the receiver)
//   record            : last complete packet {8'h00, status, x, y}
//   finished          : one-cycle pulse when record is updated
//   frame_err         : one-cycle pulse on start/parity/stop/timeout error
// master : the receiver side; slave : the line driver / packet consumer side.
interface ps2_packet_receiver_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] record;
  logic        finished;
  logic        frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output record, finished, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  record, finished, frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronizers, falling-edge detector, 11-bit
// frame FSM and inactivity timeout.
//   clk, reset     : system clock, asynchronous active-low reset
//   ps2_clk/data   : raw PS/2 lines
//   pkt_idle       : packet assembler is waiting for byte 0 (timeout disarmed in IDLE)
//   data_byte      : received byte, valid while byte_valid is high
//   byte_valid     : strobe, stop bit accepted with good parity
//   frame_err      : strobe, start/parity/stop error or timeout
// Strobes are decoded from registered state and the current edge; the packet
// layer registers them, giving one cycle from edge detection to outputs.
module ps2_frame_rx
  import ps2_packet_receiver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_idle,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  frame_state_t           state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par;
  logic [CW-1:0]          idle_cnt;

  logic clk_s;
  logic data_s;
  logic fall;
  logic cnt_clear;
  logic timeout;
  logic stop_ok;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~clk_s;
  assign cnt_clear = fall | ((state == IDLE) & pkt_idle);
  assign timeout   = ~cnt_clear & (idle_cnt == CW'(TIMEOUT_CYC - 1));
  assign stop_ok   = fall & (state == STOP) & data_s & odd_parity(shreg, par);

  assign data_byte  = shreg;
  assign byte_valid = stop_ok;
  assign frame_err  = timeout
                    | (fall & (state == IDLE) & data_s)
                    | (fall & (state == STOP) & ~stop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      // Shift the raw line into stage 0; the oldest sample falls off the top.
      clk_sync  <= SYNC_STAGES'({clk_sync, ps2_clk});
      data_sync <= SYNC_STAGES'({data_sync, ps2_data});
      clk_prev  <= clk_s;

      idle_cnt <= (cnt_clear | timeout) ? '0 : idle_cnt + CW'(1);

      if (timeout) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_s;
            state <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_packet_receiver.sv
// PS/2 mouse packet receiver top: assembles three validated bytes into a
// packet record. Byte 0 must have bit 3 set, otherwise it is dropped to
// resynchronise on packet boundaries.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : ps2_packet_receiver_if.master (PS/2 lines in; record,
//           finished, frame_err out)
module ps2_packet_receiver
  import ps2_packet_receiver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_packet_receiver_if.master  bus
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;
  byte_idx_t   byte_idx;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [31:0] record_q;
  logic [31:0] record_next;
  logic        finished_q;
  logic        frame_err_q;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .pkt_idle   (byte_idx == BYTE0),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  always_comb begin
    record_next                   = '0;
    record_next[STATUS_LSB +: 8]  = byte0;
    record_next[X_LSB +: 8]       = byte1;
    record_next[Y_LSB +: 8]       = rx_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx    <= BYTE0;
      byte0       <= '0;
      byte1       <= '0;
      record_q    <= '0;
      finished_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      finished_q  <= 1'b0;
      frame_err_q <= rx_err;
      if (rx_err) begin
        byte_idx <= BYTE0;
      end else if (rx_valid) begin
        case (byte_idx)
          BYTE0: begin
            if (rx_byte[3]) begin
              byte0    <= rx_byte;
              byte_idx <= BYTE1;
            end
          end
          BYTE1: begin
            byte1    <= rx_byte;
            byte_idx <= BYTE2;
          end
          default: begin
            record_q   <= record_next;
            finished_q <= 1'b1;
            byte_idx   <= BYTE0;
          end
        endcase
      end
    end
  end

  assign bus.record    = record_q;
  assign bus.finished  = finished_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_packet_receiver.sv
// Directed bench for ps2_packet_receiver: drives PS/2 frames bit by bit and
// checks packet records, pulse counts, output latency, error handling,
// timeout and reset behaviour against hand-computed values.
module tb_ps2_packet_receiver;
  import ps2_packet_receiver_pkg::*;

  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_packet_receiver_if bus ();

  ps2_packet_receiver #(
    .TIMEOUT_CYC (TO),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  int fin_dbl = 0;
  int err_dbl = 0;
  logic fin_prev = 1'b0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.finished) fin_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.finished && fin_prev) fin_dbl++;
    if (bus.frame_err && err_prev) err_dbl++;
    fin_prev = bus.finished;
    err_prev = bus.frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par,
                                        input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = f[i];
      repeat (5) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b0), 11);
    repeat (10) @(negedge clk);
  endtask

  int f0, e0;

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_record", bus.record, 32'h0);
    chk("reset_finished", {31'b0, bus.finished}, 32'h0);
    chk("reset_frame_err", {31'b0, bus.frame_err}, 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Packet 09 05 FB, last stop edge driven by hand to check latency.
    f0 = fin_cnt; e0 = err_cnt;
    send_byte(8'h09);
    send_byte(8'h05);
    send_bits(frame(8'hFB, 1'b0, 1'b0), 10);
    @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    bus.ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lat_not_early", {31'b0, bus.finished}, 32'h0);
    @(negedge clk);
    chk("lat_pulse", {31'b0, bus.finished}, 32'h1);
    chk("lat_record", bus.record, 32'h0009_05FB);
    @(negedge clk);
    chk("lat_single", {31'b0, bus.finished}, 32'h0);
    repeat (8) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
    chk("pkt1_fin_count", fin_cnt - f0, 32'd1);
    chk("pkt1_err_count", err_cnt - e0, 32'd0);
    chk("pkt1_left_bit", {31'b0, bus.record[LEFT_BIT]}, 32'h1);
    chk("pkt1_right_bit", {31'b0, bus.record[RIGHT_BIT]}, 32'h0);

    // Resync: 01 dropped, then 08 00 00.
    f0 = fin_cnt; e0 = err_cnt;
    send_byte(8'h01);
    chk("resync_no_err", err_cnt - e0, 32'd0);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("resync_fin_count", fin_cnt - f0, 32'd1);
    chk("resync_record", bus.record, 32'h0008_0000);

    // Parity error on byte 1, then a fresh packet 0A 10 20.
    f0 = fin_cnt; e0 = err_cnt;
    send_byte(8'h09);
    send_bits(frame(8'h05, 1'b1, 1'b0), 11);
    repeat (10) @(negedge clk);
    chk("parity_err_count", err_cnt - e0, 32'd1);
    chk("parity_record_held", bus.record, 32'h0008_0000);
    send_byte(8'h0A);
    send_byte(8'h10);
    send_byte(8'h20);
    chk("parity_fin_count", fin_cnt - f0, 32'd1);
    chk("parity_record", bus.record, 32'h000A_1020);

    // Start-bit error and stop-bit error.
    e0 = err_cnt;
    send_bits(11'h7FF, 1);
    repeat (10) @(negedge clk);
    chk("start_err_count", err_cnt - e0, 32'd1);
    e0 = err_cnt;
    send_bits(frame(8'h08, 1'b0, 1'b1), 11);
    repeat (10) @(negedge clk);
    chk("stop_err_count", err_cnt - e0, 32'd1);

    // Idle between packets never times out.
    e0 = err_cnt;
    repeat (TO + 100) @(negedge clk);
    chk("idle_no_timeout", err_cnt - e0, 32'd0);

    // Timeout after byte 1, then a full packet 18 7F 80.
    f0 = fin_cnt; e0 = err_cnt;
    send_byte(8'h0C);
    send_byte(8'h33);
    repeat (TO + 100) @(negedge clk);
    chk("timeout_err_count", err_cnt - e0, 32'd1);
    chk("timeout_no_fin", fin_cnt - f0, 32'd0);
    send_byte(8'h18);
    send_byte(8'h7F);
    send_byte(8'h80);
    chk("timeout_fin_count", fin_cnt - f0, 32'd1);
    chk("timeout_record", bus.record, 32'h0018_7F80);
    chk("timeout_err_after", err_cnt - e0, 32'd1);

    // Reset asserted during bit 4 of byte 2.
    f0 = fin_cnt;
    send_byte(8'h29);
    send_byte(8'h11);
    send_bits(frame(8'h5A, 1'b0, 1'b0), 5);
    @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_record", bus.record, 32'h0);
    chk("midreset_finished", {31'b0, bus.finished}, 32'h0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("midreset_no_fin", fin_cnt - f0, 32'd0);
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("postreset_fin_count", fin_cnt - f0, 32'd1);
    chk("postreset_record", bus.record, 32'h0008_0102);

    // Back-to-back packets.
    f0 = fin_cnt;
    send_byte(8'h2C);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("b2b_first_record", bus.record, 32'h002C_4455);
    send_byte(8'h1B);
    send_byte(8'hFF);
    send_byte(8'h01);
    repeat (20) @(negedge clk);
    chk("b2b_fin_count", fin_cnt - f0, 32'd2);
    chk("b2b_record", bus.record, 32'h001B_FF01);
    chk("fin_never_double", fin_dbl, 32'd0);
    chk("err_never_double", err_dbl, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_packet_receiver.md
PS2_PACKET_RECEIVER -- requirements
Module: ps2_packet_receiver

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYC, default 20000, meaning system-clock cycles with no PS/2 falling edge before an in-progress frame or packet is aborted.
REQ-002 The block SHALL expose parameter SYNC_STAGES, default 2, meaning synchronizer depth on ps2_clk and ps2_data.
REQ-003 clk  input  1  system clock; the block uses one clock and reset is asynchronous and active-low.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 data line, asynchronous to clk.
REQ-007 record  output  32  last complete packet: [31:24]=0, [23:16]=status byte, [15:8]=X delta, [7:0]=Y delta.
REQ-008 finished  output  1  one-cycle pulse when record is updated.
REQ-009 frame_err  output  1  one-cycle pulse on a start, parity, stop or timeout error.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a SYNC_STAGES flip-flop synchronizer; a PS/2 falling edge is synchronized-clock 1 in cycle n-1 and 0 in cycle n.
REQ-011 Data SHALL be sampled on each detected falling edge.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: a falling edge with data=0 goes to DATA (bit count 0); a falling edge with data=1 stays in IDLE and pulses frame_err.
- DATA: shift in 8 bits LSB-first, then go to PARITY.
- PARITY: capture the parity bit, then go to STOP.
- STOP: a falling edge with data=1 and odd parity over data plus parity validates the byte; otherwise pulse frame_err; in all cases return to IDLE.
REQ-013 A cycle counter SHALL reset on every falling edge and in IDLE with byte index 0; reaching TIMEOUT_CYC outside that condition SHALL force IDLE, clear the byte index, and pulse frame_err once.
REQ-014 Valid bytes SHALL assemble into a 3-byte packet using byte index 0..2.
REQ-015 A byte 0 with bit3=0 SHALL be discarded (packet resync) without frame_err, and the index SHALL stay 0.
REQ-016 Any frame error SHALL clear the byte index; the partial packet is discarded.
REQ-017 When byte 2 validates, record SHALL load {8'h00, byte0, byte1, byte2} and finished SHALL pulse in the same cycle (latency one clk after the stop-bit falling edge detection), and the byte index SHALL return to 0.
REQ-018 record SHALL hold its value between packets and is never partially updated.
REQ-019 finished and frame_err SHALL never be asserted for more than one consecutive cycle.
REQ-020 Host-to-device transmission is out of scope; both PS/2 lines are input-only.

Reset
REQ-021 While reset=0: record=32'h0, finished=0, frame_err=0, FSM=IDLE, byte index=0, counters=0, synchronizers=1 (idle-high bus).
REQ-022 Reset assertion mid-frame SHALL discard all partial state; after release, the first valid start bit begins a new packet at byte 0.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding, the record field offsets (STATUS_LSB=16, X_LSB=8, Y_LSB=0, LEFT_BIT=16, RIGHT_BIT=17), and the default TIMEOUT_CYC.
REQ-024 One sub-module, ps2_frame_rx, SHALL hold the synchronizer, edge detector, frame FSM and timeout, and output byte plus byte_valid/frame_err pulses.
REQ-025 The top level SHALL do packet assembly only.

Verification
REQ-026 Packet 0x09, 0x05, 0xFB with correct parity and stop -> one finished pulse; record=32'h0009_05FB; record[16]=1.
REQ-027 Byte 0x01 (bit3=0), then 0x08, 0x00, 0x00 -> first byte dropped, no frame_err; record=32'h0008_0000.
REQ-028 Byte 1 of a packet sent with a flipped parity bit -> frame_err pulse; the next three valid bytes 0x0A, 0x10, 0x20 -> record=32'h000A_1020.
REQ-029 ps2_clk held high for TIMEOUT_CYC cycles after byte 1 of a packet -> one frame_err pulse; a following full packet is assembled correctly from byte 0.
REQ-030 reset pulled low during bit 4 of byte 2 -> record=0, no finished pulse; a new packet after release decodes correctly.
REQ-031 Two back-to-back packets -> exactly two single-cycle finished pulses, and record holds the second packet afterwards.
